// File: rtl/dmem_pkg.sv
// dmem_pkg: access-type encodings, MMIO offsets and FAULT bit positions shared by data_memory
package dmem_pkg;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [7:0] OFF_CYCLE = 8'h00, OFF_GPIO = 8'h04, OFF_FAULT = 8'h08, OFF_CMP = 8'h0C;
  localparam int FAULT_MIS = 0, FAULT_ILL = 1;
endpackage

// File: rtl/dmem_mmio.sv
// dmem_mmio: CYCLE/GPIO/CMP registers, FAULT bit1 and the compare-match interrupt
module dmem_mmio import dmem_pkg::*; #(
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [7:0]        i_off,
  input  logic [31:0]       i_wdata,
  input  logic              i_ill,
  input  logic              i_f0,
  output logic [31:0]       o_rdata,
  output logic [GPIO_W-1:0] o_gpio,
  output logic              o_irq,
  output logic              o_f1,
  output logic              o_fclr
);
  logic [31:0] r_cycle, r_gpio, r_cmp, w_fault;
  logic r_f1, r_irq, w_cmp_we;
  always_comb begin
    w_fault = '0;
    w_fault[FAULT_MIS] = i_f0;
    w_fault[FAULT_ILL] = r_f1;
  end
  assign w_cmp_we = i_we && i_off == OFF_CMP;
  assign o_fclr = i_we && i_off == OFF_FAULT;
  assign o_rdata = i_off == OFF_CYCLE ? r_cycle : i_off == OFF_GPIO ? r_gpio :
                   i_off == OFF_FAULT ? w_fault : i_off == OFF_CMP ? r_cmp : '0;
  assign o_gpio = r_gpio[GPIO_W-1:0];
  assign o_irq = r_irq;
  assign o_f1 = r_f1;
  // the match is sampled from registered CYCLE, so irq rises one edge after equality
  always_ff @(posedge clk)
    if (i_rst) begin
      r_cycle <= '0;
      r_gpio <= '0;
      r_cmp <= 32'hFFFF_FFFF;
      r_f1 <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (i_we && i_off == OFF_GPIO) r_gpio <= i_wdata;
      if (w_cmp_we) r_cmp <= i_wdata;
      r_irq <= !w_cmp_we && (r_irq || r_cycle == r_cmp);
      r_f1 <= i_ill || (r_f1 && !o_fclr);
    end
endmodule

// File: rtl/data_memory.sv
// data_memory: RV32I data stage; byte-lane RAM with load extension, plus the MMIO
// register block when DMEM_MMIO_EN is defined
module data_memory import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       mem_datain,
  input  logic              w_enable,
  input  logic              r_enable,
  input  logic [2:0]        rw_type,
  output logic [31:0]       RD_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic r_f0;
  logic w_io, w_byte, w_half, w_word, w_unal, w_ld_mis, w_st_mis, w_ld_ill, w_st_ill;
  logic w_io_we, w_set0, w_f1, w_fclr, w_unused;
  logic [AW-1:0] w_idx;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_io_rd, w_word_rd, w_lane, w_ext;
  assign w_idx = address[AW+1:2];
  assign w_byte = rw_type == LB || rw_type == LBU;
  assign w_half = rw_type == LH || rw_type == LHU;
  assign w_word = rw_type == LW;
  assign w_unal = (w_half && address[0]) || (w_word && address[1:0] != 2'b00);
  // undefined encodings fold into the misaligned path
  assign w_ld_mis = !(w_byte || w_half || w_word) || w_unal;
  assign w_st_mis = !(rw_type == SB || rw_type == SH || rw_type == SW) || w_unal;
  assign w_ld_ill = r_enable && w_io && !w_ld_mis && !w_word;
  assign w_st_ill = w_enable && w_io && !w_st_mis && !w_word;
  assign w_io_we = w_enable && !reset && w_io && !w_st_mis && w_word;
  assign w_set0 = (r_enable && w_ld_mis) || (w_enable && w_st_mis);
  assign w_be = w_word ? 4'hF : w_half ? (address[1] ? 4'hC : 4'h3) : 4'h1 << address[1:0];
  assign w_wdata = w_word ? mem_datain : w_half ? {2{mem_datain[15:0]}} : {4{mem_datain[7:0]}};
  assign w_word_rd = w_io ? w_io_rd : r_mem[w_idx];
  assign w_lane = w_word_rd >> {address[1:0], 3'b000};
  assign w_ext = w_word ? w_word_rd :
                 w_half ? {{16{w_lane[15] && !rw_type[2]}}, w_lane[15:0]} :
                          {{24{w_lane[7] && !rw_type[2]}}, w_lane[7:0]};
  assign RD_data = r_enable && !w_ld_mis && !w_ld_ill ? w_ext : '0;
  assign fault = r_f0 || w_f1;
  always_ff @(posedge clk)
    if (w_enable && !reset && !w_io && !w_st_mis)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clk)
    if (reset) r_f0 <= 1'b0;
    else r_f0 <= w_set0 || (r_f0 && !w_fclr);
`ifdef DMEM_MMIO_EN
  assign w_io = address[31];
  assign w_unused = ^{1'b0, address[31:AW+2]};
  dmem_mmio #(.GPIO_W(GPIO_W)) u_mmio (
    .clk(clk),
    .i_rst(reset),
    .i_we(w_io_we),
    .i_off(address[7:0]),
    .i_wdata(mem_datain),
    .i_ill(w_ld_ill || w_st_ill),
    .i_f0(r_f0),
    .o_rdata(w_io_rd),
    .o_gpio(gpio_out),
    .o_irq(timer_irq),
    .o_f1(w_f1),
    .o_fclr(w_fclr)
  );
`else
  assign w_io = 1'b0;
  assign w_io_rd = '0;
  assign gpio_out = '0;
  assign timer_irq = 1'b0;
  assign w_f1 = 1'b0;
  assign w_fclr = 1'b0;
  assign w_unused = ^{1'b0, address[31:AW+2], w_io_we, w_st_ill};
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed checks of data_memory against a byte-array reference model
module tb_data_memory;
  import dmem_pkg::*;
  localparam int DW = 256;
  localparam int GW = 8;
  logic clk = 0, reset = 1, w_enable = 0, r_enable = 0;
  logic [2:0] rw_type = 0;
  logic [31:0] address = 0, mem_datain = 0;
  logic [31:0] RD_data;
  logic [GW-1:0] gpio_out;
  logic timer_irq, fault;
  int checks = 0, failures = 0;
  logic [7:0] m_mem [DW*4];
  logic [31:0] m_cyc = 0, m_gpio = 0, m_cmp = 32'hFFFF_FFFF;
  logic m_f0 = 0, m_f1 = 0, m_irq = 0;
  logic [31:0] got, exp;

  data_memory #(.DEPTH_WORDS(DW), .GPIO_W(GW)) dut (
    .clk(clk), .reset(reset), .address(address), .mem_datain(mem_datain),
    .w_enable(w_enable), .r_enable(r_enable), .rw_type(rw_type), .RD_data(RD_data),
    .gpio_out(gpio_out), .timer_irq(timer_irq), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int sz(input logic st, input logic [2:0] t);
    case (t)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return st ? 0 : 1;
      3'b101: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic mis(input logic st, input logic [2:0] t, input logic [31:0] a);
    int n = sz(st, t);
    return n == 0 || (a % n) != 0;
  endfunction

  function automatic logic is_io(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] io_rd(input logic [7:0] off);
    case (off)
      8'h00: return m_cyc;
      8'h04: return m_gpio;
      8'h08: return {30'b0, m_f1, m_f0};
      8'h0C: return m_cmp;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] t, input logic [31:0] a);
    int n, base;
    logic [31:0] v;
    if (mis(1'b0, t, a)) return 32'h0;
    n = sz(1'b0, t);
    if (is_io(a)) return n == 4 ? io_rd(a[7:0]) : 32'h0;
    base = int'(a % (DW * 4));
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(m_mem[base + i]) << (8 * i));
    if (!t[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // one bus cycle: drive, sample the combinational load, clock, then advance the model
  task automatic op(input logic rst, input logic we, input logic re, input logic [2:0] t,
                    input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] o_got, output logic [31:0] o_exp);
    logic s0, s1, wr, clr, cw;
    int n, base;
    reset = rst; w_enable = we; r_enable = re; rw_type = t; address = a; mem_datain = d;
    #1;
    o_got = RD_data;
    o_exp = re ? ld_model(t, a) : 32'h0;
    n = sz(1'b1, t);
    s0 = (re && mis(1'b0, t, a)) || (we && mis(1'b1, t, a));
    s1 = is_io(a) && ((re && !mis(1'b0, t, a) && sz(1'b0, t) != 4) || (we && !mis(1'b1, t, a) && n != 4));
    wr = we && is_io(a) && !mis(1'b1, t, a) && n == 4;
    clr = wr && a[7:0] == 8'h08;
    cw = wr && a[7:0] == 8'h0C;
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_gpio = 0; m_cmp = 32'hFFFF_FFFF; m_f0 = 0; m_f1 = 0; m_irq = 0;
    end else begin
      m_irq = !cw && (m_irq || m_cyc == m_cmp);
      m_cyc = m_cyc + 1;
      if (wr && a[7:0] == 8'h04) m_gpio = d;
      if (cw) m_cmp = d;
      m_f0 = s0 || (m_f0 && !clr);
      m_f1 = s1 || (m_f1 && !clr);
      if (we && !is_io(a) && !mis(1'b1, t, a)) begin
        base = int'(a % (DW * 4));
        for (int i = 0; i < n; i++) m_mem[base + i] = d[8*i +: 8];
      end
    end
    #1;
  endtask

  task automatic idle();
    op(0, 0, 0, LW, 0, 0, got, exp);
  endtask

  task automatic test_reset();
    op(1, 0, 0, LW, 0, 0, got, exp);
    op(1, 0, 0, LW, 0, 0, got, exp);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (gpio_out !== '0) begin failures++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    op(0, 0, 0, LW, 32'h10, 0, got, exp);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", got); end
    for (int i = 0; i < DW; i++) op(0, 1, 0, SW, 32'(i * 4), $urandom, got, exp);
  endtask

  task automatic test_byte_ext();
    op(0, 1, 0, SW, 32'h10, 32'h8081_7F01, got, exp);
    op(0, 1, 0, SB, 32'h13, 32'hABCD_EFFF, got, exp);
    op(0, 0, 1, LW, 32'h10, 0, got, exp);
    checks++; if (got !== 32'hFF81_7F01) begin failures++; $display("FAIL lw_byte got=%h exp=ff817f01", got); end
    op(0, 0, 1, LB, 32'h13, 0, got, exp);
    checks++; if (got !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb got=%h exp=ffffffff", got); end
    op(0, 0, 1, LBU, 32'h13, 0, got, exp);
    checks++; if (got !== 32'h0000_00FF) begin failures++; $display("FAIL lbu got=%h exp=000000ff", got); end
    op(0, 0, 1, LB, 32'h11, 0, got, exp);
    checks++; if (got !== 32'h0000_007F) begin failures++; $display("FAIL lb_pos got=%h exp=0000007f", got); end
  endtask

  task automatic test_half_ext();
    op(0, 1, 0, SH, 32'h22, 32'h1234_8001, got, exp);
    op(0, 0, 1, LH, 32'h22, 0, got, exp);
    checks++; if (got !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", got); end
    op(0, 0, 1, LHU, 32'h22, 0, got, exp);
    checks++; if (got !== 32'h0000_8001) begin failures++; $display("FAIL lhu got=%h exp=00008001", got); end
    op(0, 0, 1, LW, 32'h20, 0, got, exp);
    checks++; if (got !== exp || got[31:16] !== 16'h8001) begin failures++; $display("FAIL lw_half got=%h exp=%h", got, exp); end
  endtask

  task automatic test_misaligned();
    op(0, 0, 1, LW, 32'h04, 0, got, exp);
    op(0, 1, 0, SW, 32'h05, 32'hDEAD_BEEF, got, exp);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", fault); end
    op(0, 0, 1, LW, 32'h04, 0, got, exp);
    checks++; if (got !== exp) begin failures++; $display("FAIL mis_unchanged got=%h exp=%h", got, exp); end
    op(0, 0, 1, LH, 32'h23, 0, got, exp);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL mis_lh got=%h exp=0", got); end
    op(0, 0, 1, 3'b011, 32'h20, 0, got, exp);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL undef_ld got=%h exp=0", got); end
`ifdef DMEM_MMIO_EN
    op(0, 1, 0, SW, 32'h8000_0008, 0, got, exp);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_clr got=%b exp=0", fault); end
`else
    idle();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_sticky got=%b exp=1", fault); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] old;
    old = ld_model(LW, 32'h30);
    op(0, 1, 1, SW, 32'h30, 32'h5A5A_1234, got, exp);
    checks++; if (got !== old) begin failures++; $display("FAIL rw_old got=%h exp=%h", got, old); end
    op(0, 0, 1, LW, 32'h30, 0, got, exp);
    checks++; if (got !== 32'h5A5A_1234) begin failures++; $display("FAIL rw_new got=%h exp=5a5a1234", got); end
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_gpio();
    op(0, 1, 0, SW, 32'h8000_0008, 0, got, exp);
    op(0, 1, 0, SW, 32'h8000_0004, 32'h0000_01A5, got, exp);
    checks++; if (gpio_out !== 8'hA5) begin failures++; $display("FAIL gpio got=%h exp=a5", gpio_out); end
    op(0, 1, 0, SB, 32'h8000_0004, 32'h33, got, exp);
    checks++; if (fault !== 1'b1 || gpio_out !== 8'hA5) begin failures++; $display("FAIL sb_io fault=%b gpio=%h exp=1/a5", fault, gpio_out); end
    op(0, 0, 1, LW, 32'h8000_0008, 0, got, exp);
    checks++; if (got !== exp || got[1] !== 1'b1) begin failures++; $display("FAIL fault_reg got=%h exp=%h", got, exp); end
    op(0, 0, 1, LH, 32'h8000_0004, 0, got, exp);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL lh_io got=%h exp=0", got); end
    op(0, 1, 0, SW, 32'h8000_0008, 0, got, exp);
    op(0, 1, 1, SW, 32'h8000_0010, 32'h1111, got, exp);
    checks++; if (got !== 32'h0 || fault !== 1'b0) begin failures++; $display("FAIL unmapped rd=%h fault=%b exp=0/0", got, fault); end
    op(0, 1, 0, SW, 32'h8000_0000, 32'h9999, got, exp);
    op(0, 0, 1, LW, 32'h8000_0004, 0, got, exp);
    checks++; if (got !== 32'h0000_01A5) begin failures++; $display("FAIL gpio_rd got=%h exp=000001a5", got); end
  endtask

  task automatic test_timer();
    logic [31:0] prev;
    op(1, 0, 0, LW, 0, 0, got, exp);
    op(0, 1, 0, SW, 32'h8000_000C, 32'd20, got, exp);
    prev = 0;
    for (int k = 1; k < 30; k++) begin
      op(0, 0, 1, LW, 32'h8000_0000, 0, got, exp);
      checks++; if (got !== exp || got <= prev) begin failures++; $display("FAIL cycle k=%0d got=%h exp=%h", k, got, exp); end
      prev = got;
      checks++; if (timer_irq !== m_irq) begin failures++; $display("FAIL irq k=%0d got=%b exp=%b", k, timer_irq, m_irq); end
    end
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", timer_irq); end
    op(0, 1, 0, SW, 32'h8000_000C, 32'hFFFF_FFFF, got, exp);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", timer_irq); end
    op(0, 1, 0, SW, 32'h8000_000C, m_cyc + 3, got, exp);
    idle(); idle();
    op(0, 1, 0, SW, 32'h8000_000C, 32'hFFFF_FFFF, got, exp);
    checks++; if (timer_irq !== 1'b0 || m_irq !== 1'b0) begin failures++; $display("FAIL irq_race got=%b exp=0", timer_irq); end
  endtask
`else
  task automatic test_alias();
    op(0, 1, 0, SW, 32'h8000_0010, 32'h1357_2468, got, exp);
    op(0, 0, 1, LW, 32'h0000_0410, 0, got, exp);
    checks++; if (got !== 32'h1357_2468) begin failures++; $display("FAIL alias got=%h exp=13572468", got); end
    checks++; if (gpio_out !== '0 || timer_irq !== 1'b0) begin failures++; $display("FAIL tied gpio=%h irq=%b exp=0/0", gpio_out, timer_irq); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] old;
    old = ld_model(LW, 32'h40);
    op(1, 1, 0, SW, 32'h40, ~old, got, exp);
    op(1, 1, 0, SW, 32'h8000_0004, 32'h55, got, exp);
    checks++; if (gpio_out !== '0) begin failures++; $display("FAIL rst_gpio got=%h exp=0", gpio_out); end
`ifdef DMEM_MMIO_EN
    op(0, 0, 1, LW, 32'h8000_0000, 0, got, exp);
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL rst_cycle got=%h exp=0", got); end
`endif
    op(0, 0, 1, LW, 32'h40, 0, got, exp);
    checks++; if (got !== old) begin failures++; $display("FAIL rst_ram got=%h exp=%h", got, old); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 400; k++) begin
      if (is_io(32'h8000_0000) && $urandom_range(0, 7) == 0)
        a = {1'b1, 23'($urandom), 8'($urandom_range(0, 19))};
      else
        a = {1'b0, 31'($urandom)};
      op(0, 1'($urandom), 1'($urandom), 3'($urandom), a, $urandom, got, exp);
      checks++; if (got !== exp) begin failures++; $display("FAIL rand_rd k=%0d a=%h got=%h exp=%h", k, a, got, exp); end
      checks++; if (fault !== (m_f0 || m_f1)) begin failures++; $display("FAIL rand_fault k=%0d got=%b exp=%b", k, fault, m_f0 || m_f1); end
`ifdef DMEM_MMIO_EN
      checks++; if (gpio_out !== m_gpio[GW-1:0] || timer_irq !== m_irq) begin failures++; $display("FAIL rand_io k=%0d gpio=%h irq=%b exp=%h/%b", k, gpio_out, timer_irq, m_gpio[GW-1:0], m_irq); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_byte_ext();
    test_half_ext();
    test_misaligned();
    test_back_to_back();
`ifdef DMEM_MMIO_EN
    test_gpio();
    test_timer();
`else
    test_alias();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
